cat_recognizer_sequencer: RTL and testbench

APB-slave controller that sits between the APB bus and the image memory/MAC datapath of the cat recognizer. It forwards APB image writes to the image memory and owns the control/status register at address 0. On a start command it streams every stored image word, in order, into the MAC datapath through a 2-entry ready/valid buffer, then flags completion. It is the single sequencer of the calculation and arbitrates memory access between APB loading and the calculation.

---
 rtl/cat_recognizer_sequencer_if.sv | 38 +++
 rtl/cat_recognizer_sequencer.sv | 142 ++++++++++++++
 tb/tb_cat_recognizer_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cat_recognizer_sequencer_if.sv
// Bus bundle for the cat recognizer sequencer: APB slave port, image memory port and MAC stream.
// The slave modport is the sequencer's view; master is the surrounding system.
interface cat_recognizer_sequencer_if #(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 13
);
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [Amba_Addr_Depth-1:0] PADDR;
  logic [Amba_Word-1:0]       PWDATA;
  logic [Amba_Word-1:0]       PRDATA;

  logic                       mem_we;
  logic [Amba_Addr_Depth-1:0] mem_waddr;
  logic [Amba_Word-1:0]       mem_wdata;
  logic                       mem_re;
  logic [Amba_Addr_Depth-1:0] mem_raddr;
  logic [Amba_Word-1:0]       mem_rdata;

  logic                       mac_clear;
  logic                       mac_valid;
  logic [Amba_Word-1:0]       mac_data;
  logic                       mac_last;
  logic                       mac_ready;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, mem_rdata, mac_ready,
    output PRDATA, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
           mac_clear, mac_valid, mac_data, mac_last
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, mem_rdata, mac_ready,
    input  PRDATA, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
           mac_clear, mac_valid, mac_data, mac_last
  );
endinterface

// File: rtl/cat_recognizer_sequencer.sv
// Sequencer for the cat recognizer: APB control/status, image memory loading and
// in-order streaming of the image into the MAC through a 2-entry ready/valid buffer.
//
// state  | meaning
// IDLE   | waiting for a start command
// CLEAR  | one-cycle MAC accumulator clear
// STREAM | reading image words and handing them to the MAC
// DONE   | all words accepted; done flag high until the next start
module cat_recognizer_sequencer #(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 13,
  parameter int file_length     = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  cat_recognizer_sequencer_if.slave   bus,
  output logic                        busy,
  output logic                        done
);

  localparam int AW = Amba_Word;
  localparam int AD = Amba_Addr_Depth;
  localparam logic [AD:0] LAST_ADDR = (AD+1)'(file_length);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

  state_t          state_q, state_d;
  logic            access, ctrl_wr, start, abort, img_wr;
  logic            mem_we_q;
  logic [AD-1:0]   waddr_q;
  logic [AW-1:0]   wdata_q;
  logic [AD:0]     rd_addr_q;
  logic            rd_pend_q, pend_last_q;
  logic [AW-1:0]   buf_data_q [0:1];
  logic [1:0]      buf_last_q;
  logic            buf_head_q;
  logic [1:0]      buf_cnt_q;
  logic [1:0]      occ;
  logic            buf_empty, mac_valid_i, pop, mem_re_i, store, deq, tail, flush;
  logic [AW-1:0]   head_data;
  logic            head_last;

  assign access  = bus.PSEL & bus.PENABLE;
  assign ctrl_wr = access & bus.PWRITE & (bus.PADDR == '0);
  assign busy    = (state_q == CLEAR) | (state_q == STREAM);
  assign done    = (state_q == DONE);
  assign start   = ctrl_wr & bus.PWDATA[0] & ~busy;
  assign abort   = ctrl_wr & bus.PWDATA[1] & busy;
  assign img_wr  = access & bus.PWRITE & (bus.PADDR != '0) &
                   ({1'b0, bus.PADDR} <= LAST_ADDR) & ~busy;

  assign bus.PRDATA = (access & ~bus.PWRITE & (bus.PADDR == '0)) ?
                      {{(AW-2){1'b0}}, done, busy} : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      mem_we_q <= img_wr;
      if (img_wr) begin
        waddr_q <= bus.PADDR;
        wdata_q <= bus.PWDATA;
      end
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;

  // A word returning from memory is presented straight to the MAC when the buffer is empty.
  assign buf_empty   = (buf_cnt_q == 2'd0);
  assign head_data   = buf_empty ? bus.mem_rdata : buf_data_q[buf_head_q];
  assign head_last   = buf_empty ? pend_last_q : buf_last_q[buf_head_q];
  assign mac_valid_i = ~buf_empty | rd_pend_q;
  assign pop         = mac_valid_i & bus.mac_ready;
  assign occ         = buf_cnt_q + {1'b0, rd_pend_q};
  assign mem_re_i    = (state_q == STREAM) & (rd_addr_q <= LAST_ADDR) &
                       ({1'b0, occ} < (3'd2 + {2'b00, pop}));
  assign store       = rd_pend_q & ~(buf_empty & pop);
  assign deq         = pop & ~buf_empty;
  assign tail        = buf_head_q ^ buf_cnt_q[0];
  assign flush       = abort | (state_q != STREAM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q     <= (AD+1)'(1);
      rd_pend_q     <= 1'b0;
      pend_last_q   <= 1'b0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q    <= '0;
      buf_head_q    <= 1'b0;
      buf_cnt_q     <= '0;
    end else if (flush) begin
      rd_addr_q   <= (AD+1)'(1);
      rd_pend_q   <= 1'b0;
      pend_last_q <= 1'b0;
      buf_head_q  <= 1'b0;
      buf_cnt_q   <= '0;
    end else begin
      rd_pend_q   <= mem_re_i;
      pend_last_q <= (rd_addr_q == LAST_ADDR);
      if (mem_re_i) rd_addr_q <= rd_addr_q + (AD+1)'(1);
      if (store) begin
        buf_data_q[tail] <= bus.mem_rdata;
        buf_last_q[tail] <= pend_last_q;
      end
      if (deq) buf_head_q <= ~buf_head_q;
      buf_cnt_q <= buf_cnt_q + {1'b0, store} - {1'b0, deq};
    end
  end

  assign bus.mem_re    = mem_re_i;
  assign bus.mem_raddr = mem_re_i ? rd_addr_q[AD-1:0] : '0;
  assign bus.mac_clear = (state_q == CLEAR);
  assign bus.mac_valid = mac_valid_i;
  assign bus.mac_data  = mac_valid_i ? head_data : '0;
  assign bus.mac_last  = mac_valid_i & head_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = abort ? IDLE : STREAM;
      STREAM: begin
        if (abort)                  state_d = IDLE;
        else if (pop && head_last)  state_d = DONE;
      end
      DONE:    if (start) state_d = CLEAR;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cat_recognizer_sequencer.sv
// Scoreboard bench for cat_recognizer_sequencer with an 8-word image and a behavioural image memory.
module tb_cat_recognizer_sequencer;
  localparam int AW = 24;
  localparam int AD = 13;
  localparam int FL = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, done;

  always #5 clk = ~clk;

  cat_recognizer_sequencer_if #(.Amba_Word(AW), .Amba_Addr_Depth(AD)) bus ();

  cat_recognizer_sequencer #(.Amba_Word(AW), .Amba_Addr_Depth(AD), .file_length(FL)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  typedef struct packed {logic [AW-1:0] d; logic last;} mac_exp_t;
  typedef struct packed {logic [AD-1:0] a; logic [AW-1:0] d;} wr_exp_t;

  mac_exp_t      mac_q[$];
  wr_exp_t       wr_q[$];
  logic [AW-1:0] words [1:8];
  logic [AW-1:0] mem [0:15];
  int n_cmp = 0;
  int n_bad = 0;
  int flush_gen = 0;
  int acc_cnt = 0;
  int ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Image memory: read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_waddr[3:0]] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_raddr[3:0]];
  end

  // mac_ready: mode 0 always 1, mode 1 repeats 1,0,0,1.
  initial begin
    int rp;
    rp = 0;
    bus.mac_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) begin
        bus.mac_ready = (rp == 0) || (rp == 3);
        rp = (rp + 1) % 4;
      end else begin
        bus.mac_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT writes memory or hands a word to the MAC.
  initial begin
    int seen_gen, out_cnt;
    logic prev_stall;
    logic [AW-1:0] prev_data;
    mac_exp_t e;
    wr_exp_t w;
    seen_gen = 0; out_cnt = 0; prev_stall = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (flush_gen != seen_gen) begin
        seen_gen = flush_gen;
        mac_q.delete();
        out_cnt = 0;
        prev_stall = 1'b0;
      end
      if (bus.mem_we) begin
        if (wr_q.size() == 0) chk("mem_we_unexpected", 1, 0);
        else begin
          w = wr_q.pop_front();
          chk("mem_waddr", 32'(bus.mem_waddr), 32'(w.a));
          chk("mem_wdata", 32'(bus.mem_wdata), 32'(w.d));
        end
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.mac_valid), 1);
        chk("hold_data", 32'(bus.mac_data), 32'(prev_data));
      end
      if (bus.mem_re) out_cnt++;
      if (bus.mac_valid && bus.mac_ready) begin
        out_cnt--;
        acc_cnt++;
        if (mac_q.size() == 0) chk("mac_unexpected", 1, 0);
        else begin
          e = mac_q.pop_front();
          chk("mac_data", 32'(bus.mac_data), 32'(e.d));
          chk("mac_last", 32'(bus.mac_last), 32'(e.last));
        end
      end
      if (bus.mem_re) chk("outstanding_le2", 32'(out_cnt <= 2), 1);
      prev_stall = bus.mac_valid && !bus.mac_ready;
      prev_data  = bus.mac_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic any_out();
    return |{bus.PRDATA, bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.mem_re, bus.mem_raddr,
             bus.mac_clear, bus.mac_valid, bus.mac_data, bus.mac_last, busy, done};
  endfunction

  task automatic apb_wr(input logic [AD-1:0] a, input logic [AW-1:0] d);
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d; bus.PENABLE = 1'b0;
    @(posedge clk); #1 bus.PENABLE = 1'b1;
    @(posedge clk); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [AD-1:0] a, output logic [AW-1:0] d);
    bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = a; bus.PENABLE = 1'b0;
    @(posedge clk); #1 bus.PENABLE = 1'b1;
    @(negedge clk); d = bus.PRDATA;
    @(posedge clk); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic push_image();
    mac_exp_t e;
    for (int i = 1; i <= FL; i++) begin
      e.d = words[i];
      e.last = (i == FL);
      mac_q.push_back(e);
    end
  endtask

  task automatic start_plain();
    @(posedge clk); #1;
    push_image();
    apb_wr('0, 24'h000001);
  endtask

  // Start at edge T with mac_ready=1; labels are the negedge just before edge T+n.
  task automatic start_timed();
    start_plain();
    @(negedge clk);
    chk("clear_T1", 32'(bus.mac_clear), 1);
    chk("busy_T1", 32'(busy), 1);
    @(negedge clk);
    chk("re_T2", 32'(bus.mem_re), 1);
    chk("raddr_T2", 32'(bus.mem_raddr), 1);
    chk("clear_T2", 32'(bus.mac_clear), 0);
    chk("valid_T2", 32'(bus.mac_valid), 0);
    for (int n = 3; n <= FL + 3; n++) begin
      @(negedge clk);
      chk($sformatf("valid_T%0d", n), 32'(bus.mac_valid), 32'(n <= FL + 2));
      chk($sformatf("last_T%0d", n), 32'(bus.mac_last), 32'(n == FL + 2));
      chk($sformatf("busy_T%0d", n), 32'(busy), 32'(n <= FL + 2));
      chk($sformatf("done_T%0d", n), 32'(done), 32'(n == FL + 3));
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk(name, 32'(done), 1);
  endtask

  initial begin
    logic [AW-1:0] r;
    wr_exp_t w;
    int base;
    words[1] = 24'h010203; words[2] = 24'h020304; words[3] = 24'h030405; words[4] = 24'h040506;
    words[5] = 24'h050607; words[6] = 24'h060708; words[7] = 24'h070808; words[8] = 24'h080808;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;

    #2 chk("reset_outputs", 32'(any_out()), 0);
    #20 rst = 1'b1;
    @(posedge clk); #1;

    // Load: control write with no command bits, then the image.
    apb_wr('0, 24'h000000);
    @(negedge clk) chk("ctrl0_no_we", 32'(bus.mem_we), 0);
    for (int i = 1; i <= FL; i++) begin
      w.a = AD'(i);
      w.d = words[i];
      wr_q.push_back(w);
      apb_wr(AD'(i), words[i]);
      @(negedge clk) chk("we_timing", 32'(bus.mem_we), 1);
    end
    chk("busy_after_load", 32'(busy), 0);
    apb_wr(AD'(9), 24'h123456);
    @(negedge clk) chk("we_addr_oob", 32'(bus.mem_we), 0);
    apb_rd('0, r);
    chk("status_idle", 32'(r), 0);

    // Full-rate stream with exact timing.
    start_timed();
    apb_rd('0, r);
    chk("status_done", 32'(r), 2);
    apb_rd(AD'(3), r);
    chk("read_nonzero_addr", 32'(r), 0);

    // Back-pressure pattern 1,0,0,1.
    base = acc_cnt;
    ready_mode = 1;
    start_plain();
    wait_done("done_backpressure", 200);
    ready_mode = 0;
    chk("acc_backpressure", 32'(acc_cnt - base), 8);

    // Write and restart while busy are both ignored.
    base = acc_cnt;
    start_plain();
    apb_wr(AD'(3), 24'hAAAAAA);
    @(negedge clk) chk("we_while_busy", 32'(bus.mem_we), 0);
    apb_wr('0, 24'h000001);
    wait_done("done_busy_writes", 100);
    repeat (4) @(negedge clk);
    chk("acc_busy_writes", 32'(acc_cnt - base), 8);

    // Abort after three accepted words.
    base = acc_cnt;
    start_plain();
    for (int i = 0; i < 50 && acc_cnt < base + 3; i++) @(negedge clk);
    chk("abort_wait", 32'(acc_cnt >= base + 3), 1);
    apb_wr('0, 24'h000002);
    flush_gen++;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(bus.mac_valid), 0);
    chk("abort_done", 32'(done), 0);
    start_timed();

    // Asynchronous reset mid-stream.
    start_plain();
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", 32'(any_out()), 0);
    flush_gen++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    apb_rd('0, r);
    chk("status_after_reset", 32'(r), 0);
    start_timed();

    @(negedge clk);
    chk("mac_q_empty", 32'(mac_q.size()), 0);
    chk("wr_q_empty", 32'(wr_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
